// File: rtl/tick_meter_pkg.sv
// Shared definitions for the tick period meter: FSM state encoding and
// default parameter values.
package tick_meter_pkg;

    localparam int unsigned W_DEFAULT       = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/tick_meter_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // Two back-to-back flops; both clear on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/tick_meter.sv
// Measures the interval, in i_clk cycles, between successive rising edges
// of i_tick. Results are offered with a valid/ready handshake; a missing
// tick for TIMEOUT cycles drops back to IDLE with a one-cycle o_timeout.
module tick_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    output logic [W-1:0] o_period,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_timeout,
    output logic         o_overrun
);

    localparam logic [W-1:0] CNT_MAX   = '1;
    localparam logic [W-1:0] CNT_ONE   = W'(1);
    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

    logic         tick_sync;
    logic         tick_dly;
    logic         rise;
    logic         new_result;
    logic         timeout_hit;
    state_t       state;
    logic [W-1:0] cnt;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_tick),
        .o_q   (tick_sync)
    );

    // Delay flop behind the synchronizer for rising-edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_dly <= 1'b0;
        end else begin
            tick_dly <= tick_sync;
        end
    end

    // Event decode: a rise completes a period when measuring; the timeout
    // only fires when the count reaches TIMEOUT without a coincident rise.
    always_comb begin
        rise        = tick_sync & ~tick_dly;
        new_result  = (state == MEAS) && rise;
        timeout_hit = (state == MEAS) && !rise && (cnt == TIMEOUT_W);
    end

    // Measurement FSM and saturating period counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEAS;
                        cnt   <= CNT_ONE;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        cnt <= CNT_ONE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Result register with handshake, sticky overrun and timeout pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_period  <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (new_result) begin
                o_period <= cnt;
                o_valid  <= 1'b1;
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_meter.sv
// Self-checking bench for tick_meter: directed tables and sequences plus
// randomized traffic compared against an interval-based reference model.
module tb_tick_meter;

    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int          MAXV    = (1 << W) - 1;

    logic         i_clk   = 1'b0;
    logic         i_rst   = 1'b1;
    logic         i_tick  = 1'b0;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_period;
    logic         o_valid;
    logic         o_timeout;
    logic         o_overrun;

    int total = 0;
    int bad   = 0;
    int tmo_seen = 0;

    tick_meter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_tick    (i_tick),
        .o_period  (o_period),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_timeout (o_timeout),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works in edge indices: a tick level first seen high at edge e is an
    // event at edge e+2; a period is the distance between two events.
    int  t = 0;
    int  pend[$];
    bit  prev_tick = 1'b0;
    bit  armed = 1'b0;
    int  last_ev = 0;
    logic m_valid = 1'b0;
    logic m_over  = 1'b0;
    logic m_tmo   = 1'b0;
    int  m_period = 0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend.delete();
            prev_tick = 1'b0;
            armed     = 1'b0;
            m_valid   = 1'b0;
            m_over    = 1'b0;
            m_tmo     = 1'b0;
            m_period  = 0;
        end else begin
            bit ev;
            bit res_new;
            int res;
            int elapsed;
            ev = 1'b0;
            res_new = 1'b0;
            res = 0;
            m_tmo = 1'b0;
            if (pend.size() > 0 && pend[0] == t) begin
                ev = 1'b1;
                void'(pend.pop_front());
            end
            if (armed) begin
                elapsed = t - last_ev;
                if (ev) begin
                    res     = (elapsed > MAXV) ? MAXV : elapsed;
                    res_new = 1'b1;
                    last_ev = t;
                end else if (elapsed == int'(TIMEOUT)) begin
                    armed = 1'b0;
                    m_tmo = 1'b1;
                end
            end else if (ev) begin
                armed   = 1'b1;
                last_ev = t;
            end
            if (res_new) begin
                if (m_valid && !i_ready) m_over = 1'b1;
                m_period = res;
                m_valid  = 1'b1;
            end else if (m_valid && i_ready) begin
                m_valid = 1'b0;
            end
            if (i_tick && !prev_tick) pend.push_back(t + 2);
            prev_tick = i_tick;
            t++;
        end
    end

    // Continuous comparison against the model, mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("model_period",  32'(o_period),  32'(m_period));
            check("model_valid",   32'(o_valid),   32'(m_valid));
            check("model_timeout", 32'(o_timeout), 32'(m_tmo));
            check("model_overrun", 32'(o_overrun), 32'(m_over));
            if (o_timeout) tmo_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Clock-divider style pulse train: one high cycle every n cycles.
    task automatic run_div(input int n, input int pulses);
        for (int p = 0; p < pulses; p++) begin
            i_tick = 1'b1;
            step();
            i_tick = 1'b0;
            for (int k = 1; k < n; k++) step();
        end
    endtask

    typedef struct {
        int n;
        int pulses;
        int exp_period;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int k;
        int mode;
        int div_n;
        int phase;

        tbl[0] = '{n: 4,  pulses: 6, exp_period: 4};
        tbl[1] = '{n: 7,  pulses: 6, exp_period: 7};
        tbl[2] = '{n: 5,  pulses: 6, exp_period: 5};
        tbl[3] = '{n: 2,  pulses: 6, exp_period: 2};
        tbl[4] = '{n: 16, pulses: 3, exp_period: 16};

        // Reset state
        repeat (2) step();
        check("reset_period",  32'(o_period),  0);
        check("reset_valid",   32'(o_valid),   0);
        check("reset_timeout", 32'(o_timeout), 0);
        check("reset_overrun", 32'(o_overrun), 0);
        i_rst = 1'b0;
        step();

        // Divider sweep with ready held high, periods switched back to back
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_div(tbl[i].n, tbl[i].pulses);
            check($sformatf("table_period_n%0d", tbl[i].n), 32'(o_period), 32'(tbl[i].exp_period));
            check($sformatf("table_overrun_n%0d", tbl[i].n), 32'(o_overrun), 0);
        end
        check("table_no_timeout", 32'(tmo_seen), 0);

        // Ticks stop after a 4-cycle period: timeout after TIMEOUT cycles
        run_div(4, 4);
        i_tick = 1'b1;
        k = 0;
        do begin
            step();
            i_tick = 1'b0;
            k++;
        end while (!o_timeout && k < 40);
        check("timeout_latency", 32'(k), 19);
        check("timeout_period_kept", 32'(o_period), 4);
        step();
        check("timeout_one_cycle", 32'(o_timeout), 0);
        check("timeout_count", 32'(tmo_seen), 1);
        i_ready = 1'b0;
        run_div(12, 1);
        check("idle_arm_only", 32'(o_valid), 0);

        // Overrun with the consumer stalled, then a single accept
        run_div(4, 5);
        repeat (2) step();
        check("overrun_flag",   32'(o_overrun), 1);
        check("overrun_period", 32'(o_period),  4);
        check("overrun_valid",  32'(o_valid),   1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("accept_clears_valid", 32'(o_valid), 0);
        check("overrun_sticky", 32'(o_overrun), 1);

        // Reset mid-measurement while a result is pending
        run_div(5, 3);
        check("pre_reset_valid", 32'(o_valid), 1);
        i_rst = 1'b1;
        #1;
        check("async_rst_period",  32'(o_period),  0);
        check("async_rst_valid",   32'(o_valid),   0);
        check("async_rst_timeout", 32'(o_timeout), 0);
        check("async_rst_overrun", 32'(o_overrun), 0);
        step();
        i_rst = 1'b0;
        run_div(6, 1);
        check("post_reset_first_event", 32'(o_valid), 0);
        run_div(6, 1);
        check("post_reset_valid",  32'(o_valid),  1);
        check("post_reset_period", 32'(o_period), 6);

        // Accept in the same cycle as a new result
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        for (int j = 0; j < 16; j++) begin
            i_tick  = (j == 0 || j == 4 || j == 10);
            i_ready = (j == 12);
            step();
            if (j == 11) check("coincide_before", 32'(o_period), 4);
            if (j == 12) begin
                check("coincide_valid",   32'(o_valid),   1);
                check("coincide_period",  32'(o_period),  6);
                check("coincide_overrun", 32'(o_overrun), 0);
            end
        end
        i_tick  = 1'b0;
        i_ready = 1'b0;

        // Randomized traffic against the model
        mode = 0;
        div_n = 4;
        phase = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                mode  = $urandom_range(0, 2);
                div_n = $urandom_range(2, 20);
                phase = 0;
                if ($urandom_range(0, 3) == 0) begin
                    i_rst = 1'b1;
                    step();
                    i_rst = 1'b0;
                end
            end
            case (mode)
                0:       i_tick = ($urandom_range(0, 3) == 0);
                1:       i_tick = ($urandom_range(0, 24) == 0);
                default: begin
                    i_tick = (phase == 0);
                    phase  = (phase + 1 >= div_n) ? 0 : phase + 1;
                end
            endcase
            i_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        i_tick = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
